// File: rtl/meas_pkg.sv
// Shared FSM state encoding, mode codes and small helpers for the oscillator
// measurement scheduler.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_GATE    = 3'd2,
        ST_LATCH   = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    // Codes 2'b10 and 2'b11 both mean "alternate, inverter first".
    localparam logic [1:0] MODE_INV  = 2'b00;
    localparam logic [1:0] MODE_NAND = 2'b01;

    localparam logic SRC_INV  = 1'b0;
    localparam logic SRC_NAND = 1'b1;

    function automatic logic is_alt(input logic [1:0] m);
        return m[1];
    endfunction

    function automatic logic pick_src(input logic [1:0] m, input logic alt);
        case (m)
            MODE_INV:  return SRC_INV;
            MODE_NAND: return SRC_NAND;
            default:   return alt;
        endcase
    endfunction

    function automatic logic [7:0] sat_byte(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/osc_meas_sched_if.sv
// UART transmit handshake between the measurement scheduler and the UART.
// tx_data is held stable by the master from tx_start until the transfer ends.
interface osc_meas_sched_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (output tx_start, output tx_data, input tx_busy);
    modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter: loading N raises done on the Nth cycle after the load
// edge and holds it until the next load; never wraps.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/osc_meas_sched.sv
// Sequences ring-oscillator warm-up, counter gating, result latch and a UART
// byte per measurement; transmission waits on tx_busy and always completes.
module osc_meas_sched
    import meas_pkg::*;
#(
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 10
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             run,
    input  logic [1:0]       mode,
    output logic             osc_en_inv,
    output logic             osc_en_nand,
    output logic             osc_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] result,
    output logic             result_src,
    output logic             result_valid,
    output logic             busy,
    osc_meas_sched_if.master uart
);
    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);

    state_t        state;
    logic          src;
    logic          alt_tgl;
    logic          tx_armed;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic          tx_done;
    logic          settle_go;
    logic          gate_go;
    logic          next_src;
    logic          t_done;
    logic [TW-1:0] t_load_val;

    // tx_armed gates the busy sample so the UART has two cycles to raise tx_busy.
    assign tx_done    = (state == ST_WAIT_TX) && tx_armed && !uart.tx_busy;
    assign settle_go  = run && ((state == ST_IDLE) || tx_done);
    assign gate_go    = (state == ST_SETTLE) && run && t_done;
    assign next_src   = pick_src(mode, alt_tgl);
    assign t_load_val = gate_go ? TW'(GATE_CYCLES) : TW'(SETTLE_CYCLES);

    cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (settle_go || gate_go),
        .load_val (t_load_val),
        .done     (t_done)
    );

    assign busy          = (state != ST_IDLE);
    assign uart.tx_start = tx_start_q;
    assign uart.tx_data  = tx_data_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            src          <= SRC_INV;
            alt_tgl      <= SRC_INV;
            tx_armed     <= 1'b0;
            osc_en_inv   <= 1'b0;
            osc_en_nand  <= 1'b0;
            osc_sel      <= 1'b0;
            cnt_clr      <= 1'b0;
            cnt_en       <= 1'b0;
            result       <= '0;
            result_src   <= 1'b0;
            result_valid <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            cnt_clr      <= 1'b0;
            result_valid <= 1'b0;
            tx_start_q   <= 1'b0;
            case (state)
                ST_IDLE: ;
                ST_SETTLE, ST_GATE: begin
                    if (!run) begin
                        state       <= ST_IDLE;
                        osc_en_inv  <= 1'b0;
                        osc_en_nand <= 1'b0;
                        osc_sel     <= 1'b0;
                        cnt_en      <= 1'b0;
                    end else if (t_done) begin
                        state  <= (state == ST_SETTLE) ? ST_GATE : ST_LATCH;
                        cnt_en <= (state == ST_SETTLE);
                    end
                end
                ST_LATCH: begin
                    state        <= ST_SEND;
                    result       <= count;
                    result_src   <= src;
                    result_valid <= 1'b1;
                    tx_data_q    <= sat_byte(32'(count));
                    osc_en_inv   <= 1'b0;
                    osc_en_nand  <= 1'b0;
                    osc_sel      <= 1'b0;
                end
                ST_SEND: begin
                    if (tx_start_q) begin
                        state    <= ST_WAIT_TX;
                        tx_armed <= 1'b0;
                    end else if (!uart.tx_busy) begin
                        tx_start_q <= 1'b1;
                    end
                end
                ST_WAIT_TX: begin
                    tx_armed <= 1'b1;
                    if (tx_done && !run) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Source is chosen here only, so mode changes land at the next warm-up.
            if (settle_go) begin
                state       <= ST_SETTLE;
                src         <= next_src;
                osc_en_inv  <= (next_src == SRC_INV);
                osc_en_nand <= (next_src == SRC_NAND);
                osc_sel     <= next_src;
                cnt_clr     <= 1'b1;
                if (is_alt(mode)) begin
                    alt_tgl <= ~alt_tgl;
                end
            end
        end
    end
endmodule

// File: tb/tb_osc_meas_sched.sv
// Directed bench for osc_meas_sched with GATE=20, SETTLE=4 and a simple UART busy model.
module tb_osc_meas_sched;
    localparam int GATE   = 20;
    localparam int SETTLE = 4;

    logic       clk_in;
    logic       rst_n;
    logic       run;
    logic [1:0] mode;
    logic       osc_en_inv, osc_en_nand, osc_sel, cnt_clr, cnt_en;
    logic [9:0] count_val;
    logic [9:0] result;
    logic       result_src, result_valid, busy;

    osc_meas_sched_if uart ();

    osc_meas_sched #(
        .GATE_CYCLES   (GATE),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (10)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .run          (run),
        .mode         (mode),
        .osc_en_inv   (osc_en_inv),
        .osc_en_nand  (osc_en_nand),
        .osc_sel      (osc_sel),
        .cnt_clr      (cnt_clr),
        .cnt_en       (cnt_en),
        .count        (count_val),
        .result       (result),
        .result_src   (result_src),
        .result_valid (result_valid),
        .busy         (busy),
        .uart         (uart)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [1:0] mode;
        logic [9:0] count;
        logic [9:0] exp_result;
        logic [7:0] exp_txd;
        logic       exp_src;
    } vec_t;

    vec_t vecs [6];

    int   vectors, miscompares;
    int   busy_left;
    logic force_busy;
    int   clr_cnt, settle_cnt, gate_cnt, start_cnt, rv_cnt, both_on, sel_err;
    logic settle_run;
    logic [7:0] last_txd;
    logic src_q [$];

    // UART model plus activity monitor, sampled on the falling edge.
    always @(negedge clk_in) begin
        if (uart.tx_start) busy_left = 6;
        else if (busy_left != 0) busy_left = busy_left - 1;
        uart.tx_busy = force_busy || (busy_left != 0);
        if (cnt_clr) begin
            clr_cnt++;
            settle_run = 1'b1;
            settle_cnt = 0;
        end
        if (settle_run) begin
            if (cnt_en) settle_run = 1'b0;
            else settle_cnt++;
        end
        if (cnt_en) gate_cnt++;
        if (uart.tx_start) begin
            start_cnt++;
            last_txd = uart.tx_data;
        end
        if (result_valid) begin
            rv_cnt++;
            src_q.push_back(result_src);
        end
        if (osc_en_inv && osc_en_nand) both_on++;
        if ((osc_en_inv && osc_sel) || (osc_en_nand && !osc_sel)) sel_err++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic clear_mon();
        clr_cnt = 0; settle_cnt = 0; gate_cnt = 0; start_cnt = 0;
        rv_cnt = 0; both_on = 0; sel_err = 0; settle_run = 1'b0;
        last_txd = 8'h00;
        src_q.delete();
    endtask

    task automatic wait_rv();
        tick();
        for (int i = 0; i < 300 && !result_valid; i++) tick();
        chk("rv_seen", 32'(result_valid), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick();
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        clear_mon();
        mode = v.mode;
        count_val = v.count;
        run = 1'b1;
        wait_rv();
        run = 1'b0;
        chk($sformatf("v%0d_result_at_rv", idx), 32'(result), 32'(v.exp_result));
        chk($sformatf("v%0d_en_off_send", idx), 32'({osc_en_inv, osc_en_nand}), 32'd0);
        wait_idle();
        chk($sformatf("v%0d_result", idx), 32'(result), 32'(v.exp_result));
        chk($sformatf("v%0d_src", idx), 32'(result_src), 32'(v.exp_src));
        chk($sformatf("v%0d_tx_data", idx), 32'(last_txd), 32'(v.exp_txd));
        chk($sformatf("v%0d_tx_starts", idx), 32'(start_cnt), 32'd1);
        chk($sformatf("v%0d_gate_len", idx), 32'(gate_cnt), 32'(GATE));
        chk($sformatf("v%0d_settle_len", idx), 32'(settle_cnt), 32'(SETTLE));
        chk($sformatf("v%0d_clr_pulses", idx), 32'(clr_cnt), 32'd1);
        chk($sformatf("v%0d_rv_pulses", idx), 32'(rv_cnt), 32'd1);
        chk($sformatf("v%0d_en_excl", idx), 32'(both_on + sel_err), 32'd0);
    endtask

    initial begin
        int s [3];
        rst_n = 1'b0; run = 1'b0; mode = 2'b00; count_val = '0; force_busy = 1'b0;
        vectors = 0; miscompares = 0; busy_left = 0;
        clear_mon();

        vecs[0] = '{2'b00, 10'd137,  10'd137,  8'h89, 1'b0};
        vecs[1] = '{2'b01, 10'd700,  10'd700,  8'hFF, 1'b1};
        vecs[2] = '{2'b00, 10'd255,  10'd255,  8'hFF, 1'b0};
        vecs[3] = '{2'b01, 10'd256,  10'd256,  8'hFF, 1'b1};
        vecs[4] = '{2'b00, 10'd0,    10'd0,    8'h00, 1'b0};
        vecs[5] = '{2'b11, 10'd1023, 10'd1023, 8'hFF, 1'b0};

        repeat (3) tick();
        chk("rst_ctl", 32'({osc_en_inv, osc_en_nand, osc_sel, cnt_clr, cnt_en,
                            result_valid, uart.tx_start, busy}), 32'd0);
        chk("rst_result", 32'({result_src, result}), 32'd0);
        chk("rst_tx_data", 32'(uart.tx_data), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 32'(busy), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // tx_busy held for 50 cycles while sitting in SEND.
        clear_mon();
        mode = 2'b00; count_val = 10'd42; run = 1'b1;
        wait_rv();
        run = 1'b0;
        force_busy = 1'b1;
        repeat (50) tick();
        chk("hold_no_start", 32'(start_cnt), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        force_busy = 1'b0;
        wait_idle();
        chk("hold_one_start", 32'(start_cnt), 32'd1);
        chk("hold_tx_data", 32'(last_txd), 32'h2A);

        // Reset asserted in WAIT_TX.
        clear_mon();
        mode = 2'b00; count_val = 10'd99; run = 1'b1;
        for (int i = 0; i < 300 && !uart.tx_start; i++) tick();
        chk("wtx_start_seen", 32'(uart.tx_start), 32'd1);
        tick();
        rst_n = 1'b0; run = 1'b0;
        tick();
        chk("wtx_rst_ctl", 32'({osc_en_inv, osc_en_nand, osc_sel, cnt_clr, cnt_en,
                                result_valid, uart.tx_start, busy}), 32'd0);
        chk("wtx_rst_result", 32'({result_src, result}), 32'd0);
        chk("wtx_rst_tx_data", 32'(uart.tx_data), 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();

        // Alternate mode, three back-to-back measurements.
        clear_mon();
        mode = 2'b10; count_val = 10'd300; run = 1'b1;
        for (int k = 0; k < 3; k++) wait_rv();
        run = 1'b0;
        wait_idle();
        s = '{-1, -1, -1};
        for (int k = 0; k < 3 && k < src_q.size(); k++) s[k] = int'(src_q[k]);
        chk("alt_count", 32'(src_q.size()), 32'd3);
        chk("alt_src0", 32'(s[0]), 32'd0);
        chk("alt_src1", 32'(s[1]), 32'd1);
        chk("alt_src2", 32'(s[2]), 32'd0);
        chk("alt_both_on", 32'(both_on), 32'd0);
        chk("alt_sel_err", 32'(sel_err), 32'd0);
        chk("alt_gate_total", 32'(gate_cnt), 32'(3 * GATE));
        chk("alt_tx_starts", 32'(start_cnt), 32'd3);
        chk("alt_tx_data", 32'(last_txd), 32'hFF);

        // run dropped in the middle of GATE.
        clear_mon();
        mode = 2'b01; count_val = 10'd500; run = 1'b1;
        for (int i = 0; i < 300 && !cnt_en; i++) tick();
        chk("abort_gate_seen", 32'(cnt_en), 32'd1);
        repeat (5) tick();
        run = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_ctl", 32'({osc_en_inv, osc_en_nand, cnt_en}), 32'd0);
        repeat (10) tick();
        chk("abort_no_rv", 32'(rv_cnt), 32'd0);
        chk("abort_no_start", 32'(start_cnt), 32'd0);
        chk("abort_result_kept", 32'(result), 32'd300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/osc_meas_sched.md
OSC_MEAS_SCHED -- requirements
Module: osc_meas_sched

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 1000: counter gate window length in clk_in cycles.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 16: oscillator warm-up before gating, in cycles.
REQ-003 The block SHALL have parameter CNT_W, default 10: width of the edge-count bus.
REQ-004 The block SHALL have port clk_in, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port run, input, 1 bit: level request for continuous measurement.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 = inverter oscillator only, 01 = NAND oscillator only, 10/11 = alternate, starting with the inverter oscillator.
REQ-008 The block SHALL have ports osc_en_inv and osc_en_nand, outputs, 1 bit each: oscillator enables.
REQ-009 The block SHALL have port osc_sel, output, 1 bit: mux select, 0 = inverter, 1 = NAND.
REQ-010 The block SHALL have ports cnt_clr and cnt_en, outputs, 1 bit each: counter clear and counter gate.
REQ-011 The block SHALL have port count, input, CNT_W bits: counter value.
REQ-012 The block SHALL have port result, output, CNT_W bits: last latched count.
REQ-013 The block SHALL have port result_src, output, 1 bit: source oscillator of result.
REQ-014 The block SHALL have port result_valid, output, 1 bit: one-cycle strobe when result updates.
REQ-015 The block SHALL have ports tx_start (output, 1 bit), tx_data (output, 8 bits) and tx_busy (input, 1 bit): UART transmit handshake.
REQ-016 The block SHALL have port busy, output, 1 bit: asserted whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, SETTLE, GATE, LATCH, SEND and WAIT_TX.
REQ-018 In IDLE with run=1, the FSM SHALL move to SETTLE on the next edge, selecting the source from mode and the alternate toggle.
REQ-019 On entry to SETTLE, the FSM SHALL assert only the selected oscillator enable, drive osc_sel to match, and pulse cnt_clr for exactly one cycle.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with cnt_en=0 throughout.
REQ-021 GATE SHALL hold cnt_en=1 for exactly GATE_CYCLES consecutive cycles.
REQ-022 LATCH SHALL last one cycle and SHALL capture count into result and the source into result_src; result_valid SHALL be 1 in the following cycle.
REQ-023 In SEND, the FSM SHALL assert tx_start for exactly one cycle, and only while tx_busy=0; it SHALL hold in SEND while tx_busy=1.
REQ-024 tx_data SHALL equal result[7:0] if result<256, else 8'hFF (saturate), and SHALL stay stable from tx_start until WAIT_TX exits.
REQ-025 WAIT_TX SHALL exit when tx_busy=0, sampled no earlier than 2 cycles after tx_start.
REQ-026 On WAIT_TX exit, the FSM SHALL go to SETTLE if run=1 (toggling the source in alternate mode), else to IDLE.
REQ-027 Oscillator enables SHALL be 0 in IDLE, SEND and WAIT_TX; both enables SHALL never be 1 together.
REQ-028 If run drops during SETTLE or GATE, the FSM SHALL abort to IDLE on the next edge, with no LATCH and no result_valid.
REQ-029 If run drops during LATCH, SEND or WAIT_TX, the current transmission SHALL complete before the FSM returns to IDLE.
REQ-030 A mode change SHALL take effect only at the next SETTLE entry.
REQ-031 Cycle counters SHALL be sized for max(GATE_CYCLES, SETTLE_CYCLES) and SHALL not wrap within a state.

Reset
REQ-032 While rst_n=0 at a clk_in edge, the FSM SHALL enter IDLE, even mid-transmission.
REQ-033 On reset, all outputs SHALL be 0, result and result_src SHALL be 0, and the alternate toggle SHALL select the inverter oscillator.

Structure
REQ-034 State encodings and the mode codes SHALL live in a shared package, meas_pkg.
REQ-035 One sub-module, cycle_timer (loadable down-counter with a done flag), SHALL be reused for both SETTLE and GATE timing.

Verification
REQ-036 Bench SHALL check: GATE=20, SETTLE=4, mode=00, run=1, count=137 -> cnt_en high exactly 20 cycles, result=137, tx_data=8'h89, one tx_start.
REQ-037 Bench SHALL check: mode=10, run held for 3 measurements -> result_src sequence 0,1,0 and osc_en_inv/osc_en_nand never both 1.
REQ-038 Bench SHALL check: count=700 -> tx_data=8'hFF and result=700.
REQ-039 Bench SHALL check: tx_busy held 1 for 50 cycles at SEND -> tx_start withheld, then a single pulse after release.
REQ-040 Bench SHALL check: run dropped mid-GATE -> IDLE next cycle, no result_valid, enables 0.
REQ-041 Bench SHALL check: rst_n=0 during WAIT_TX -> IDLE and all outputs 0 on the next edge.
